// File: rtl/uart_receiver.sv
// 8-N-1 UART receiver with a one-deep valid/ready holding register and error reporting.
// Define UART_RX_PARITY_EN to receive 8-E-1 frames with an even-parity check.
module uart_receiver #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic [7:0] err_cnt,
  output logic [3:0] is_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF_BIT - 1);

  // state  | meaning
  // IDLE   | line idle, waiting for a start edge
  // START  | half-bit wait, confirm start bit is still low
  // DATA   | sampling D0..D7 at bit centres
  // PARITY | sampling the parity bit (parity build only)
  // STOP   | sampling the stop bit, deciding complete / error
  // BREAK  | line stuck low after a framing error, wait for high
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_DATA   = 4'd2,
    S_PARITY = 4'd3,
    S_STOP   = 4'd4,
    S_BREAK  = 4'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_sync2;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_ferr, r_ovr, r_perr;
  logic [7:0]       r_err_cnt;
  logic             w_rx_s;
  logic             w_done, w_ferr, w_perr;
  logic             w_par_bad;

  assign w_rx_s = r_sync2;

`ifdef UART_RX_PARITY_EN
  logic r_par, w_par_nxt;
  assign w_par_bad = ^{r_shift, r_par};
`else
  assign w_par_bad = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
    w_perr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == C_HALF_LAST) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          // a start bit that has gone high again by mid-bit is treated as noise
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[7:1]};
          w_idx_nxt   = r_idx + 1'b1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_par_nxt   = w_rx_s;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_nxt = '0;
          w_perr    = w_par_bad;
          if (w_rx_s) begin
            w_done      = ~w_par_bad;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
      r_perr    <= 1'b0;
      r_err_cnt <= '0;
`ifdef UART_RX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
      // a consumer taking the held byte frees the slot in the same cycle
      if (w_done && (!r_valid || rx_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
      r_ovr  <= w_done & r_valid & ~rx_ready;
      r_ferr <= w_ferr;
      r_perr <= w_perr;
      if ((r_ferr || r_ovr || r_perr) && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
  assign parity_err = r_perr;
  assign err_cnt    = r_err_cnt;
  assign is_state   = r_state;

endmodule
